// File: rtl/dtformat_pkg.sv
// Shared definitions for the signed-magnitude to two's complement stream converter:
// FSM state encoding and the per-word format conversion.
package dtformat_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // Widest word the conversion function handles; callers pass their own width.
   localparam int unsigned MAX_DATAW = 32;
   typedef logic [MAX_DATAW-1:0] word_t;

   // Converts a dataw-bit signed-magnitude word (zero-extended into word_t) to
   // dataw-bit two's complement. Negative zero maps to all zeros, so the most
   // negative two's complement code can never come out of this function.
   function automatic word_t sm2c_word(input word_t word, input int unsigned dataw);
      word_t mag_mask;
      word_t sign_mask;
      word_t mag;
      logic  sign;
      mag_mask  = (word_t'(1) << (dataw - 1)) - word_t'(1);
      sign_mask = mag_mask + word_t'(1);
      sign      = |(word & sign_mask);
      mag       = word & mag_mask;
      if (sign && (mag != '0)) begin
         sm2c_word = (~mag + word_t'(1)) & (mag_mask | sign_mask);
      end else begin
         sm2c_word = mag;
      end
   endfunction

endpackage

// File: rtl/sm2c_lane.sv
// One lane of the converter: purely combinational SM -> 2C word conversion plus
// a flag marking a negative-zero input word.
module sm2c_lane
   import dtformat_pkg::*;
#(
   parameter int DATAW = 4
) (
   input  logic [DATAW-1:0] word_i,
   output logic [DATAW-1:0] word_2c_o,
   output logic             negzero_o
);

   assign word_2c_o = DATAW'(sm2c_word(word_t'(word_i), DATAW));
   assign negzero_o = word_i[DATAW-1] && (word_i[DATAW-2:0] == '0);

endmodule

// File: rtl/sm2c_stream_converter.sv
// Captures a whole N-word signed-magnitude vector, then streams it out as
// N/LANES beats of LANES two's complement words with valid/ready handshaking.
module sm2c_stream_converter
   import dtformat_pkg::*;
#(
   parameter  int N      = 256,
   parameter  int DATAW  = 4,
   parameter  int LANES  = 16,
   localparam int NCHUNK = N / LANES,
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [N-1:0][DATAW-1:0]     data_sm_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   output logic [LANES-1:0][DATAW-1:0] data_2c_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [CW-1:0]               chunk_idx_o,
   output logic                        out_last_o,
   output logic [LANES-1:0]            negzero_o
);

   localparam int            IW         = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

   if ((N % LANES) != 0 || DATAW < 2 || DATAW > int'(MAX_DATAW)) begin : g_bad_cfg
      $error("sm2c_stream_converter: N must be a multiple of LANES and 2 <= DATAW <= MAX_DATAW");
   end

   state_t                    state_q, state_d;
   logic [CW-1:0]             chunk_q, chunk_d;
   logic                      capture;
   logic [N-1:0][DATAW-1:0]   cap_q;
   logic [LANES-1:0][DATAW-1:0] chunk_sm;
   logic [LANES-1:0]          lane_negzero;
   logic                      send;

   assign send = (state_q == ST_SEND);

   // Next-state and chunk counter: accept in IDLE, walk the chunks in SEND.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
      state_d = state_q;
      chunk_d = chunk_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               capture = 1'b1;
               chunk_d = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (out_ready_i) begin
               if (chunk_q == LAST_CHUNK) begin
                  chunk_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  chunk_d = chunk_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and chunk counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         chunk_q <= '0;
      end else begin
         state_q <= state_d;
         chunk_q <= chunk_d;
      end
   end

   // Whole-vector capture register, loaded on the accepting handshake.
   always_ff @(posedge clk_i) begin
      // NOTE: this wide register is reset on purpose: data_2c_o must read zero right after reset.
      if (!rst_ni) begin
         cap_q <= '0;
      end else if (capture) begin
         cap_q <= data_sm_i;
      end
   end

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [IW-1:0] idx;
      assign idx         = IW'(int'(chunk_q) * LANES + j);
      assign chunk_sm[j] = cap_q[idx];

      sm2c_lane #(
         .DATAW(DATAW)
      ) u_lane (
         .word_i   (chunk_sm[j]),
         .word_2c_o(data_2c_o[j]),
         .negzero_o(lane_negzero[j])
      );
   end

   assign in_ready_o  = !send;
   assign out_valid_o = send;
   assign out_last_o  = send && (chunk_q == LAST_CHUNK);
   assign chunk_idx_o = chunk_q;
   assign negzero_o   = send ? lane_negzero : '0;

endmodule

// File: doc/sm2c_stream_converter.md
SM2C_STREAM_CONVERTER -- requirements
Module: sm2c_stream_converter

Interface
REQ-001 SHALL have parameter N, default 256, number of words per input vector.
REQ-002 SHALL have parameter DATAW, default 4, bits per word (sign bit plus DATAW-1 magnitude bits).
REQ-003 SHALL have parameter LANES, default 16, words emitted per output beat; N SHALL be an integer multiple of LANES.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset; synchronous and active-low.
REQ-006 SHALL have port data_sm_i, input, [N-1:0][DATAW-1:0], input vector in signed-magnitude format.
REQ-007 SHALL have port in_valid_i, input, 1, data_sm_i valid.
REQ-008 SHALL have port in_ready_o, output, 1, block can accept a vector.
REQ-009 SHALL have port data_2c_o, output, [LANES-1:0][DATAW-1:0], current chunk in two's complement format.
REQ-010 SHALL have port out_valid_o, output, 1, data_2c_o valid.
REQ-011 SHALL have port out_ready_i, input, 1, downstream accepts the beat.
REQ-012 SHALL have port chunk_idx_o, output, $clog2(N/LANES) (min 1), index of the current chunk.
REQ-013 SHALL have port out_last_o, output, 1, current beat is the final chunk of the vector.
REQ-014 SHALL have port negzero_o, output, [LANES-1:0], per-lane flag: input word was negative zero.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and SEND.
REQ-016 In IDLE, in_ready_o SHALL be 1 and out_valid_o SHALL be 0.
REQ-017 On in_valid_i && in_ready_o, data_sm_i SHALL be captured whole into an internal register, the chunk counter SHALL be cleared to 0, and the FSM SHALL move to SEND.
REQ-018 In SEND, in_ready_o SHALL be 0 and out_valid_o SHALL be 1; in_valid_i SHALL be ignored.
REQ-019 data_2c_o lane j SHALL equal the converted captured word chunk_idx*LANES+j; chunk 0 SHALL be presented in the cycle after acceptance (latency 1).
REQ-020 Conversion per word: sign 0 -> word unchanged; sign 1 with nonzero magnitude -> DATAW-bit two's complement of -magnitude; sign 1 with zero magnitude -> all zeros, with negzero_o for that lane set to 1.
REQ-021 negzero_o SHALL be 0 for every lane whose word is not negative zero, and all 0 when out_valid_o is 0.
REQ-022 Representable range SHALL be -(2^(DATAW-1)-1) to +(2^(DATAW-1)-1); the most negative two's complement code SHALL never be produced.
REQ-023 Data and chunk_idx_o SHALL hold stable while out_valid_o && !out_ready_i.
REQ-024 On out_valid_o && out_ready_i with chunk < N/LANES-1, the counter SHALL increment by 1.
REQ-025 out_last_o SHALL be 1 only when in SEND and chunk == N/LANES-1.
REQ-026 On a handshake with out_last_o = 1, the FSM SHALL return to IDLE; in_ready_o SHALL rise in the next cycle (no same-cycle accept).
REQ-027 Steady-state throughput SHALL be one vector per N/LANES+1 cycles with out_ready_i held at 1.
REQ-028 When N == LANES, the single beat SHALL have chunk_idx_o = 0 and out_last_o = 1.

Reset
REQ-029 While rst_ni is 0 at a clock edge, the FSM SHALL go to IDLE, the counter SHALL go to 0, and the capture register SHALL clear to 0.
REQ-030 After reset: in_ready_o = 1, out_valid_o = 0, out_last_o = 0, chunk_idx_o = 0, negzero_o = 0, data_2c_o = 0.
REQ-031 Reset asserted mid-SEND SHALL abort the vector; no further beats of that vector SHALL be emitted.

Structure
REQ-032 A shared package dtformat_pkg SHALL hold the FSM state typedef and a SM-to-2C word conversion function parameterised by DATAW.
REQ-033 Per-word conversion SHALL be a combinational sub-module sm2c_lane (inputs: word; outputs: 2C word, negzero flag), instantiated LANES times.
REQ-034 An elaboration-time check SHALL fail if N mod LANES != 0 or DATAW < 2.

Verification
REQ-035 DATAW=4: words 0111, 1001, 1111, 0000 -> 0111, 1111, 1001, 0000 with negzero 0.
REQ-036 Word 1000 -> 0000 with negzero_o lane = 1; all other lanes in the beat have negzero 0.
REQ-037 N=256, LANES=16, out_ready_i=1 -> 16 beats, chunk_idx 0..15, out_last_o only on beat 15, in_ready_o back to 1 one cycle after.
REQ-038 Random out_ready_i backpressure -> no beat lost or duplicated; data is stable while stalled; 2C-to-SM round trip equals input (except negative zero -> 0000).
REQ-039 rst_ni low at chunk 5 -> next cycle IDLE, out_valid_o = 0; next vector starts at chunk 0.
REQ-040 in_valid_i held high during SEND with a changing data_sm_i -> the emitted data matches only the originally captured vector.
